branch_resolve_unit: RTL

Execute-stage counterpart of the tournament (Gshare/Local/meta) predictor. Captures per-branch prediction metadata at fetch into an in-flight FIFO, then pops and checks it against the actual branch outcome at EX. It produces:
- the registered training bundle consumed by the predictor's `*_in` ports;
- per-component correctness flags for the choice table;
- a mispredict flush with redirect PC for the front end.

---
 rtl/branch_resolve_unit.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - EX-stage branch resolution, predictor training and mispredict flush
// Optional statistics counters are built when BRU_STATS_EN is defined.
module branch_resolve_unit #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       Reset,
  input  logic                       pred_valid,
  output logic                       enq_ready,
  input  logic                       pred_choose_G,
  input  logic                       pred_G_taken,
  input  logic                       pred_L_taken,
  input  logic [31:0]                pred_G_target,
  input  logic [31:0]                pred_L_target,
  input  logic [31:0]                pred_fallthrough,
  input  logic [4:0]                 pred_index,
  input  logic [4:0]                 pred_GHPT_index,
  input  logic [4:0]                 pred_G_BTB_index,
  input  logic [4:0]                 pred_GHR,
  input  logic [3:0]                 pred_LHR_index,
  input  logic [3:0]                 pred_LHPT_index,
  input  logic [3:0]                 pred_L_BTB_index,
  input  logic                       res_valid,
  input  logic                       res_taken,
  input  logic [31:0]                res_target,
  output logic                       upd_valid,
  output logic                       upd_choose_G,
  output logic                       upd_G_correct,
  output logic                       upd_L_correct,
  output logic                       upd_taken,
  output logic [31:0]                upd_target,
  output logic [4:0]                 upd_index,
  output logic [4:0]                 upd_GHPT_index,
  output logic [4:0]                 upd_G_BTB_index,
  output logic [4:0]                 upd_GHR,
  output logic [3:0]                 upd_LHR_index,
  output logic [3:0]                 upd_LHPT_index,
  output logic [3:0]                 upd_L_BTB_index,
  output logic                       flush,
  output logic [31:0]                redirect_pc,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       err_underflow,
  output logic [31:0]                stat_branches,
  output logic [31:0]                stat_mispredicts
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef struct packed {
    logic        choose_G;
    logic        G_taken;
    logic        L_taken;
    logic [31:0] G_target;
    logic [31:0] L_target;
    logic [31:0] fallthrough;
    logic [4:0]  index;
    logic [4:0]  GHPT_index;
    logic [4:0]  G_BTB_index;
    logic [4:0]  GHR;
    logic [3:0]  LHR_index;
    logic [3:0]  LHPT_index;
    logic [3:0]  L_BTB_index;
  } entry_t;

  typedef enum logic {RUN, FLUSH} state_t;

  entry_t          mem [DEPTH];
  entry_t          wr_entry;
  entry_t          head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [FW-1:0]   fcnt;
  state_t          state;

  logic enq, pop, ct, g_ok, l_ok, mispredict;
  logic [31:0] tgt;

  assign wr_entry = '{choose_G: pred_choose_G, G_taken: pred_G_taken, L_taken: pred_L_taken,
                      G_target: pred_G_target, L_target: pred_L_target,
                      fallthrough: pred_fallthrough, index: pred_index,
                      GHPT_index: pred_GHPT_index, G_BTB_index: pred_G_BTB_index,
                      GHR: pred_GHR, LHR_index: pred_LHR_index,
                      LHPT_index: pred_LHPT_index, L_BTB_index: pred_L_BTB_index};

  assign head       = mem[rd_ptr];
  assign enq_ready  = (count != CW'(DEPTH)) && (state == RUN);
  assign enq        = pred_valid && enq_ready;
  assign pop        = res_valid && (count != '0) && (state == RUN);
  assign fifo_count = count;

  assign ct         = head.choose_G ? head.G_taken  : head.L_taken;
  assign tgt        = head.choose_G ? head.G_target : head.L_target;
  assign g_ok       = (head.G_taken == res_taken) && (!res_taken || head.G_target == res_target);
  assign l_ok       = (head.L_taken == res_taken) && (!res_taken || head.L_target == res_target);
  assign mispredict = (ct != res_taken) || (res_taken && tgt != res_target);

  // Storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (enq)
      mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state           <= RUN;
      fcnt            <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      flush           <= 1'b0;
      redirect_pc     <= '0;
      err_underflow   <= 1'b0;
      upd_valid       <= 1'b0;
      upd_choose_G    <= 1'b0;
      upd_G_correct   <= 1'b0;
      upd_L_correct   <= 1'b0;
      upd_taken       <= 1'b0;
      upd_target      <= '0;
      upd_index       <= '0;
      upd_GHPT_index  <= '0;
      upd_G_BTB_index <= '0;
      upd_GHR         <= '0;
      upd_LHR_index   <= '0;
      upd_LHPT_index  <= '0;
      upd_L_BTB_index <= '0;
    end else begin
      upd_valid <= pop;
      if (pop) begin
        upd_choose_G    <= head.choose_G;
        upd_G_correct   <= g_ok;
        upd_L_correct   <= l_ok;
        upd_taken       <= res_taken;
        upd_target      <= res_target;
        upd_index       <= head.index;
        upd_GHPT_index  <= head.GHPT_index;
        upd_G_BTB_index <= head.G_BTB_index;
        upd_GHR         <= head.GHR;
        upd_LHR_index   <= head.LHR_index;
        upd_LHPT_index  <= head.LHPT_index;
        upd_L_BTB_index <= head.L_BTB_index;
      end
      case (state)
        RUN: begin
          if (res_valid && count == '0)
            err_underflow <= 1'b1;
          if (pop && mispredict) begin
            // Everything younger than the mispredicted branch is wrong-path: drop it all.
            state       <= FLUSH;
            fcnt        <= FW'(FLUSH_CYCLES - 1);
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            flush       <= 1'b1;
            redirect_pc <= res_taken ? res_target : head.fallthrough;
          end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(enq) - CW'(pop);
          end
        end
        FLUSH: begin
          if (fcnt == '0) begin
            state <= RUN;
            flush <= 1'b0;
          end else begin
            fcnt <= fcnt - 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef BRU_STATS_EN
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (pop) begin
      if (stat_branches != 32'hFFFF_FFFF)
        stat_branches <= stat_branches + 32'd1;
      if (mispredict && stat_mispredicts != 32'hFFFF_FFFF)
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`else
  assign stat_branches    = 32'd0;
  assign stat_mispredicts = 32'd0;
`endif

endmodule
